// File: rtl/cs_rst_seq_pkg.sv
// Shared types and default timing for the cs_rst reset sequencer.
// State encodings are fixed because downstream debug tooling decodes them.
package cs_rst_seq_pkg;

   typedef enum logic [2:0] {
      ST_ALL   = 3'd0,
      ST_GAP   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DEV   = 3'd3,
      ST_IDLE  = 3'd4
   } state_t;

   localparam int DEF_HOLD_ALL = 16;
   localparam int DEF_GAP_CYC  = 8;
   localparam int DEF_HOLD_DEV = 16;
   localparam int DEF_DRAIN_TO = 256;
   localparam int DEF_CNT_W    = 8;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Width of the shared hold counter: wide enough for the longest load value.
   function automatic int hold_cnt_w(input int ha, input int gc, input int hd, input int dt);
      return $clog2(max4(ha, gc, hd, dt)) + 1;
   endfunction

endpackage

// File: rtl/cs_rst_cnt.sv
// Loadable down-counter shared by every timed state of the reset sequencer.
// Saturates at zero; o_zero tells the FSM the current hold has expired.
module cs_rst_cnt #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   // NOTE: non-blocking assignments for every register so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/cs_rst_seq.sv
// Reset sequencer: stretches power-on reset, releases rst_all before rst_dev,
// and drains the ADC datapath before a device-only reset.
module cs_rst_seq
   import cs_rst_seq_pkg::*;
#(
   parameter int HOLD_ALL = DEF_HOLD_ALL,
   parameter int GAP_CYC  = DEF_GAP_CYC,
   parameter int HOLD_DEV = DEF_HOLD_DEV,
   parameter int DRAIN_TO = DEF_DRAIN_TO,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_all,
   input  logic             req_dev,
   input  logic             dev_idle,
   output logic             rst_all,
   output logic             rst_dev,
   output logic             busy,
   output logic             done,
   output logic             drain_tmo,
   output logic [CNT_W-1:0] seq_cnt
);

   localparam int CW = hold_cnt_w(HOLD_ALL, GAP_CYC, HOLD_DEV, DRAIN_TO);

   // A hold of N cycles loads N-1 and leaves on the cycle the count reads zero.
   localparam logic [CW-1:0] LD_ALL   = CW'(HOLD_ALL - 1);
   localparam logic [CW-1:0] LD_GAP   = CW'(GAP_CYC - 1);
   localparam logic [CW-1:0] LD_DEV   = CW'(HOLD_DEV - 1);
   localparam logic [CW-1:0] LD_DRAIN = CW'(DRAIN_TO - 1);

   state_t           r_state;
   logic             r_post_rst;
   logic             r_rst_all;
   logic             r_rst_dev;
   logic             r_busy;
   logic             r_done;
   logic             r_drain_tmo;
   logic [CNT_W-1:0] r_seq_cnt;

   state_t           w_next;
   logic             w_load;
   logic [CW-1:0]    w_load_val;
   logic             w_zero;
   logic             w_rst_all;
   logic             w_rst_dev;
   logic             w_busy;
   logic             w_done;
   logic             w_drain_tmo;

   cs_rst_cnt #(
      .W (CW)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_val  (w_load_val),
      .o_zero (w_zero)
   );

   // State and registered outputs; outputs are decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_ALL;
         r_post_rst  <= 1'b1;
         r_rst_all   <= 1'b1;
         r_rst_dev   <= 1'b1;
         r_busy      <= 1'b1;
         r_done      <= 1'b0;
         r_drain_tmo <= 1'b0;
         r_seq_cnt   <= '0;
      end else begin
         r_state     <= w_next;
         r_post_rst  <= 1'b0;
         r_rst_all   <= w_rst_all;
         r_rst_dev   <= w_rst_dev;
         r_busy      <= w_busy;
         r_done      <= w_done;
         r_drain_tmo <= w_drain_tmo;
         if (w_done) begin
            r_seq_cnt <= r_seq_cnt + CNT_W'(1);
         end
      end
   end

   // The first cycle after reset counts as entry into ALL, so the hold starts here.
   always_comb begin
      // NOTE: every comb output gets a default first so no latch is inferred.
      w_next     = r_state;
      w_load     = 1'b0;
      w_load_val = '0;
      if (r_post_rst) begin
         w_next     = ST_ALL;
         w_load     = 1'b1;
         w_load_val = LD_ALL;
      end else if (req_all) begin
         w_next     = ST_ALL;
         w_load     = 1'b1;
         w_load_val = LD_ALL;
      end else begin
         unique case (r_state)
            ST_ALL: begin
               if (w_zero) begin
                  w_next     = ST_GAP;
                  w_load     = 1'b1;
                  w_load_val = LD_GAP;
               end
            end
            ST_GAP: begin
               if (w_zero) w_next = ST_IDLE;
            end
            ST_DRAIN: begin
               if (dev_idle || w_zero) begin
                  w_next     = ST_DEV;
                  w_load     = 1'b1;
                  w_load_val = LD_DEV;
               end
            end
            ST_DEV: begin
               if (w_zero) w_next = ST_IDLE;
            end
            ST_IDLE: begin
               if (req_dev) begin
                  w_next     = ST_DRAIN;
                  w_load     = 1'b1;
                  w_load_val = LD_DRAIN;
               end
            end
            default: begin
               w_next     = ST_ALL;
               w_load     = 1'b1;
               w_load_val = LD_ALL;
            end
         endcase
      end
   end

   // Output decode; rst_all is only ever high together with rst_dev.
   always_comb begin
      w_rst_all   = (w_next == ST_ALL);
      w_rst_dev   = (w_next == ST_ALL) || (w_next == ST_GAP) || (w_next == ST_DEV);
      w_busy      = (w_next != ST_IDLE);
      w_done      = (w_next == ST_IDLE) && (r_state != ST_IDLE) && !r_post_rst;
      w_drain_tmo = (r_state == ST_DRAIN) && (w_next == ST_DEV) && !dev_idle;
   end

   assign rst_all   = r_rst_all;
   assign rst_dev   = r_rst_dev;
   assign busy      = r_busy;
   assign done      = r_done;
   assign drain_tmo = r_drain_tmo;
   assign seq_cnt   = r_seq_cnt;

endmodule

// File: tb/tb_cs_rst_seq.sv
// Self-checking bench for cs_rst_seq: directed scenarios plus a random soak,
// compared every cycle against a timestamp-based model of the sequences.
module tb_cs_rst_seq;

   localparam int HOLD_ALL = 16;
   localparam int GAP_CYC  = 8;
   localparam int HOLD_DEV = 16;
   localparam int DRAIN_TO = 256;
   localparam int CNT_W    = 8;

   localparam int M_IDLE = 0;
   localparam int M_FULL = 1;
   localparam int M_DEV  = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_all = 1'b0;
   logic             req_dev = 1'b0;
   logic             dev_idle = 1'b0;
   logic             rst_all;
   logic             rst_dev;
   logic             busy;
   logic             done;
   logic             drain_tmo;
   logic [CNT_W-1:0] seq_cnt;

   cs_rst_seq #(
      .HOLD_ALL (HOLD_ALL),
      .GAP_CYC  (GAP_CYC),
      .HOLD_DEV (HOLD_DEV),
      .DRAIN_TO (DRAIN_TO),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_all   (req_all),
      .req_dev   (req_dev),
      .dev_idle  (dev_idle),
      .rst_all   (rst_all),
      .rst_dev   (rst_dev),
      .busy      (busy),
      .done      (done),
      .drain_tmo (drain_tmo),
      .seq_cnt   (seq_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a sequence is a mode plus the edge index at which each phase began.
   int               k = 0;
   int               mode = M_FULL;
   int               t_full = 1;
   int               t_drain = 0;
   int               t_dev = 0;
   bit               draining = 1'b0;
   bit               e_rst_all, e_rst_dev, e_busy, e_done, e_tmo;
   logic [CNT_W-1:0] e_seq = '0;

   // Per-scenario measurements taken from the DUT outputs.
   int               n_all_hi, n_dev_hi, n_drain, n_done, n_tmo;
   bit               rand_idle = 1'b0;

   task automatic model_edge();
      int age;
      k++;
      e_done = 1'b0;
      e_tmo  = 1'b0;
      if (rst) begin
         mode   = M_FULL;
         t_full = k + 1;
         e_seq  = '0;
      end else begin
         if (req_all) begin
            mode   = M_FULL;
            t_full = k;
         end else if (mode == M_IDLE && req_dev) begin
            mode     = M_DEV;
            draining = 1'b1;
            t_drain  = k;
         end else if (mode == M_DEV && draining) begin
            if (dev_idle) begin
               draining = 1'b0;
               t_dev    = k;
            end else if (k - t_drain == DRAIN_TO) begin
               draining = 1'b0;
               t_dev    = k;
               e_tmo    = 1'b1;
            end
         end
         if ((mode == M_FULL && k - t_full == HOLD_ALL + GAP_CYC) ||
             (mode == M_DEV && !draining && k - t_dev == HOLD_DEV)) begin
            mode   = M_IDLE;
            e_done = 1'b1;
            e_seq  = e_seq + 1'b1;
         end
      end
      e_rst_all = 1'b0;
      e_rst_dev = 1'b0;
      if (mode == M_FULL) begin
         age       = k - t_full;
         e_rst_all = (age < HOLD_ALL);
         e_rst_dev = (age < HOLD_ALL + GAP_CYC);
      end else if (mode == M_DEV) begin
         e_rst_dev = !draining;
      end
      e_busy = (mode != M_IDLE);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, k);
      end
   endtask

   task automatic clear_meas();
      n_all_hi = 0;
      n_dev_hi = 0;
      n_drain  = 0;
      n_done   = 0;
      n_tmo    = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("cycle {all,dev,busy,done,tmo,seq}",
            32'({rst_all, rst_dev, busy, done, drain_tmo, seq_cnt}),
            32'({e_rst_all, e_rst_dev, e_busy, e_done, e_tmo, e_seq}));
      n_all_hi += int'(rst_all);
      n_dev_hi += int'(rst_dev);
      n_drain  += int'(busy && !rst_dev);
      n_done   += int'(done);
      n_tmo    += int'(drain_tmo);
      if (rand_idle) dev_idle = ($urandom_range(0, 3) != 0);
   endtask

   task automatic run_until_idle(input string tag, input int budget);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while ((busy || e_busy) && n < budget);
      if (busy || e_busy) begin
         n_vec++;
         n_err++;
         $error("FAIL %s: still busy after %0d cycles, required idle", tag, budget);
      end
   endtask

   task automatic pulse(input bit a, input bit d);
      req_all = a;
      req_dev = d;
      tick();
      req_all = 1'b0;
      req_dev = 1'b0;
   endtask

   initial begin
      logic [CNT_W-1:0] seq_before;

      // 1: power-on stretch
      rst = 1'b1;
      repeat (5) tick();
      check("reset rst_all", 32'(rst_all), 32'd1);
      check("reset seq_cnt", 32'(seq_cnt), 32'd0);
      rst = 1'b0;
      clear_meas();
      run_until_idle("poweron", 100);
      check("poweron rst_all cycles", n_all_hi, HOLD_ALL);
      check("poweron rst_dev cycles", n_dev_hi, HOLD_ALL + GAP_CYC);
      check("poweron done count", n_done, 1);
      check("poweron seq_cnt", 32'(seq_cnt), 32'd1);

      // 2: dev-only with datapath already idle
      dev_idle = 1'b1;
      clear_meas();
      pulse(1'b0, 1'b1);
      run_until_idle("dev idle path", 100);
      check("dev rst_dev cycles", n_dev_hi, HOLD_DEV);
      check("dev rst_all cycles", n_all_hi, 0);
      check("dev drain cycles", n_drain, 1);
      check("dev done count", n_done, 1);
      check("dev seq_cnt", 32'(seq_cnt), 32'd2);

      // 3a: drain timeout
      dev_idle = 1'b0;
      clear_meas();
      pulse(1'b0, 1'b1);
      run_until_idle("drain timeout", 400);
      check("tmo drain cycles", n_drain, DRAIN_TO);
      check("tmo pulse count", n_tmo, 1);

      // 3b: datapath goes idle during drain
      clear_meas();
      pulse(1'b0, 1'b1);
      repeat (39) tick();
      dev_idle = 1'b1;
      run_until_idle("drain early", 100);
      check("early drain cycles", n_drain, 40);
      check("early tmo count", n_tmo, 0);

      // 4: full request aborts a running dev phase
      clear_meas();
      pulse(1'b0, 1'b1);
      repeat (6) tick();
      pulse(1'b1, 1'b0);
      run_until_idle("abort", 100);
      check("abort rst_all cycles", n_all_hi, HOLD_ALL);
      check("abort done count", n_done, 1);
      check("abort seq_cnt", 32'(seq_cnt), 32'd5);

      // 5: collisions
      clear_meas();
      pulse(1'b1, 1'b1);
      run_until_idle("collide", 100);
      check("collide drain cycles", n_drain, 0);
      check("collide rst_all cycles", n_all_hi, HOLD_ALL);
      clear_meas();
      pulse(1'b1, 1'b0);
      repeat (HOLD_ALL + 2) tick();
      pulse(1'b0, 1'b1);
      run_until_idle("dev in gap", 100);
      check("gap-dev rst_dev cycles", n_dev_hi, HOLD_ALL + GAP_CYC);
      check("gap-dev done count", n_done, 1);

      // 6a: 256 dev sequences wrap seq_cnt back to where it started
      seq_before = seq_cnt;
      rand_idle  = 1'b1;
      for (int i = 0; i < 256; i++) begin
         pulse(1'b0, 1'b1);
         run_until_idle("wrap seq", 400);
      end
      rand_idle = 1'b0;
      check("wrap seq_cnt", 32'(seq_cnt), 32'(seq_before));

      // 6b: reset mid-GAP
      pulse(1'b1, 1'b0);
      repeat (HOLD_ALL + 3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midgap rst_all", 32'(rst_all), 32'd1);
      check("midgap seq_cnt", 32'(seq_cnt), 32'd0);
      run_until_idle("after midgap", 100);

      // Random soak with rare resets
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 499) == 0);
         req_all  = ($urandom_range(0, 63) == 0);
         req_dev  = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 7) == 0) dev_idle = ~dev_idle;
         tick();
      end
      rst     = 1'b0;
      req_all = 1'b0;
      req_dev = 1'b0;
      dev_idle = 1'b1;
      run_until_idle("soak drain", 400);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
